// File: rtl/decode_branch_resolver_ras.sv
// Decode-stage branch resolver: computes per-lane targets, flags the first mispredicted
// lane for a front-end redirect, and maintains a circular return address stack.
module decode_branch_resolver_ras #(
  parameter int WIDTH     = 2,
  parameter int PC_WIDTH  = 32,
  parameter int RAS_DEPTH = 8,
  parameter int PTR_WIDTH = $clog2(RAS_DEPTH),
  parameter int LANE_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [WIDTH-1:0]             valid_i,
  input  logic [WIDTH*PC_WIDTH-1:0]    pc_i,
  input  logic [WIDTH*PC_WIDTH-1:0]    imm_i,
  input  logic [WIDTH-1:0]             is_cond_i,
  input  logic [WIDTH-1:0]             is_jal_i,
  input  logic [WIDTH-1:0]             is_jalr_i,
  input  logic [WIDTH-1:0]             is_call_i,
  input  logic [WIDTH-1:0]             is_ret_i,
  input  logic [WIDTH-1:0]             is_serial_i,
  input  logic [WIDTH-1:0]             pred_taken_i,
  input  logic [WIDTH*PC_WIDTH-1:0]    pred_addr_i,
  input  logic                         recover_i,
  input  logic [PTR_WIDTH-1:0]         recover_ptr_i,
  input  logic [PTR_WIDTH:0]           recover_cnt_i,
  output logic [WIDTH-1:0]             valid_o,
  output logic                         flush_o,
  output logic [LANE_W-1:0]            flush_lane_o,
  output logic [PC_WIDTH-1:0]          redirect_pc_o,
  output logic [WIDTH*PC_WIDTH-1:0]    pred_addr_o,
  output logic [WIDTH*PTR_WIDTH-1:0]   ckpt_ptr_o,
  output logic [WIDTH*(PTR_WIDTH+1)-1:0] ckpt_cnt_o
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(RAS_DEPTH);

  logic [PTR_WIDTH-1:0] topPtr;
  logic [PTR_WIDTH:0]   rasCnt;
  logic [PC_WIDTH-1:0]  rasStack [RAS_DEPTH];

  logic [PTR_WIDTH-1:0] ptrNext;
  logic [PTR_WIDTH:0]   cntNext;
  logic [PC_WIDTH-1:0]  stackNext [RAS_DEPTH];

  logic                 scanOn;
  logic                 checkOn;
  logic                 flushHit;
  logic [LANE_W-1:0]    flushLane;
  logic [PC_WIDTH-1:0]  redirectPc;
  logic [WIDTH-1:0]     laneValid;
  logic [PC_WIDTH-1:0]  lanePc;
  logic [PC_WIDTH-1:0]  seqPc;
  logic [PC_WIDTH-1:0]  laneTarget;
  logic [PC_WIDTH-1:0]  lanePred;
  logic                 retHit;
  logic                 laneFlush;
  logic                 isCtrl;

  always_comb begin
    ptrNext     = topPtr;
    cntNext     = rasCnt;
    stackNext   = rasStack;
    scanOn      = 1'b1;
    checkOn     = 1'b1;
    flushHit    = 1'b0;
    flushLane   = '0;
    redirectPc  = '0;
    laneValid   = valid_i;
    lanePc      = '0;
    seqPc       = '0;
    laneTarget  = '0;
    lanePred    = '0;
    retHit      = 1'b0;
    laneFlush   = 1'b0;
    isCtrl      = 1'b0;
    pred_addr_o = pred_addr_i;
    ckpt_ptr_o  = '0;
    ckpt_cnt_o  = '0;

    // Sequential per-lane chain: each lane sees the RAS state left by the older lanes.
    for (int i = 0; i < WIDTH; i++) begin
      ckpt_ptr_o[i*PTR_WIDTH +: PTR_WIDTH]       = ptrNext;
      ckpt_cnt_o[i*(PTR_WIDTH+1) +: PTR_WIDTH+1] = cntNext;
      if (scanOn && valid_i[i]) begin
        lanePc    = pc_i[i*PC_WIDTH +: PC_WIDTH];
        lanePred  = pred_addr_i[i*PC_WIDTH +: PC_WIDTH];
        seqPc     = lanePc + PC_WIDTH'(4);
        retHit    = is_ret_i[i] && (cntNext != '0);
        isCtrl    = is_cond_i[i] || is_jal_i[i] || is_jalr_i[i];
        laneFlush = 1'b0;
        if (is_cond_i[i] || is_jal_i[i])
          laneTarget = lanePc + imm_i[i*PC_WIDTH +: PC_WIDTH];
        else if (retHit)
          laneTarget = stackNext[ptrNext];
        else
          laneTarget = seqPc;

        if (checkOn) begin
          if (is_serial_i[i]) begin
            laneFlush  = 1'b1;
            laneTarget = seqPc;
          end else if (!isCtrl && pred_taken_i[i]) begin
            laneFlush  = 1'b1;
            laneTarget = seqPc;
          end else if (is_jal_i[i] || (is_cond_i[i] && pred_taken_i[i])) begin
            laneFlush = (lanePred != laneTarget);
          end else if (is_jalr_i[i]) begin
            if (retHit)
              laneFlush = (lanePred != laneTarget);
            else
              checkOn = 1'b0;  // unpredictable indirect: younger lanes cannot be judged
          end
        end

        // A lane carrying both call and ret pops first, then pushes.
        if (retHit) begin
          ptrNext = ptrNext - 1'b1;
          cntNext = cntNext - 1'b1;
        end
        if (is_call_i[i]) begin
          ptrNext            = ptrNext + 1'b1;
          stackNext[ptrNext] = seqPc;
          if (cntNext != FULL_CNT)
            cntNext = cntNext + 1'b1;
        end

        if (laneFlush) begin
          flushHit   = 1'b1;
          flushLane  = LANE_W'(i);
          redirectPc = laneTarget;
          pred_addr_o[i*PC_WIDTH +: PC_WIDTH] = laneTarget;
          scanOn     = 1'b0;
        end
      end else begin
        scanOn = 1'b0;
      end
    end

    for (int i = 0; i < WIDTH; i++) begin
      if (flushHit && (i > int'(flushLane)))
        laneValid[i] = 1'b0;
    end
  end

  assign flush_o       = flushHit && !rst && !recover_i;
  assign valid_o       = (rst || recover_i) ? '0 : laneValid;
  assign flush_lane_o  = flushLane;
  assign redirect_pc_o = redirectPc;

  always_ff @(posedge clk) begin
    if (rst) begin
      topPtr <= '0;
      rasCnt <= '0;
      for (int e = 0; e < RAS_DEPTH; e++)
        rasStack[e] <= '0;
    end else if (recover_i) begin
      topPtr <= recover_ptr_i;
      rasCnt <= recover_cnt_i;
    end else if (!stall) begin
      topPtr   <= ptrNext;
      rasCnt   <= cntNext;
      rasStack <= stackNext;
    end
  end

endmodule

// File: tb/tb_decode_branch_resolver_ras.sv
// Directed bench for decode_branch_resolver_ras (WIDTH=2, PC_WIDTH=32, RAS_DEPTH=8).
module tb_decode_branch_resolver_ras;

  localparam int W  = 2;
  localparam int PW = 32;
  localparam int PT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [W-1:0]    valid_i;
  logic [W*PW-1:0] pc_i, imm_i, pred_addr_i;
  logic [W-1:0]    is_cond_i, is_jal_i, is_jalr_i, is_call_i, is_ret_i, is_serial_i, pred_taken_i;
  logic            recover_i;
  logic [PT-1:0]   recover_ptr_i;
  logic [PT:0]     recover_cnt_i;
  logic [W-1:0]    valid_o;
  logic            flush_o;
  logic [0:0]      flush_lane_o;
  logic [PW-1:0]   redirect_pc_o;
  logic [W*PW-1:0] pred_addr_o;
  logic [W*PT-1:0] ckpt_ptr_o;
  logic [W*(PT+1)-1:0] ckpt_cnt_o;

  int tests = 0;
  int failed = 0;

  decode_branch_resolver_ras dut (
    .clk(clk), .rst(rst), .stall(stall), .valid_i(valid_i), .pc_i(pc_i), .imm_i(imm_i),
    .is_cond_i(is_cond_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .is_call_i(is_call_i),
    .is_ret_i(is_ret_i), .is_serial_i(is_serial_i), .pred_taken_i(pred_taken_i),
    .pred_addr_i(pred_addr_i), .recover_i(recover_i), .recover_ptr_i(recover_ptr_i),
    .recover_cnt_i(recover_cnt_i), .valid_o(valid_o), .flush_o(flush_o),
    .flush_lane_o(flush_lane_o), .redirect_pc_o(redirect_pc_o), .pred_addr_o(pred_addr_o),
    .ckpt_ptr_o(ckpt_ptr_o), .ckpt_cnt_o(ckpt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    valid_i = '0; pc_i = '0; imm_i = '0; pred_addr_i = '0;
    is_cond_i = '0; is_jal_i = '0; is_jalr_i = '0; is_call_i = '0;
    is_ret_i = '0; is_serial_i = '0; pred_taken_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkState(input string tag, input logic [PT-1:0] ptr, input logic [PT:0] cnt);
    chk({tag, "_ptr"}, 64'(ckpt_ptr_o[PT-1:0]), 64'(ptr));
    chk({tag, "_cnt"}, 64'(ckpt_cnt_o[PT:0]), 64'(cnt));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; recover_i = 1'b0; recover_ptr_i = '0; recover_cnt_i = '0;
    clearIn();

    // 1: jal mispredicted, shown during reset (suppressed) and after
    valid_i = 2'b11;
    is_jal_i[0] = 1'b1; pc_i[31:0] = 32'h100; imm_i[31:0] = 32'h40; pred_addr_i[31:0] = 32'h104;
    pc_i[63:32] = 32'h104; pred_addr_i[63:32] = 32'hAAA;
    tick();
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    rst = 1'b0;
    #2;
    chkState("rst_state", 3'd0, 4'd0);
    chk("jal_flush", 64'(flush_o), 64'd1);
    chk("jal_lane", 64'(flush_lane_o), 64'd0);
    chk("jal_redirect", 64'(redirect_pc_o), 64'h140);
    chk("jal_valid", 64'(valid_o), 64'b01);
    chk("jal_pa0", 64'(pred_addr_o[31:0]), 64'h140);
    chk("jal_pa1", 64'(pred_addr_o[63:32]), 64'hAAA);
    tick();

    // 2: call then ret in one group, return forwarded from the same cycle
    clearIn();
    valid_i = 2'b11;
    is_call_i[0] = 1'b1; pc_i[31:0] = 32'h200;
    is_jalr_i[1] = 1'b1; is_ret_i[1] = 1'b1; pc_i[63:32] = 32'h300; pred_addr_i[63:32] = 32'h204;
    #2;
    chk("cr_flush", 64'(flush_o), 64'd0);
    chk("cr_ckcnt1", 64'(ckpt_cnt_o[7:4]), 64'd1);
    chk("cr_ckptr1", 64'(ckpt_ptr_o[5:3]), 64'd1);
    chk("cr_valid", 64'(valid_o), 64'b11);
    tick();
    clearIn();
    #2;
    chkState("cr_after", 3'd0, 4'd0);

    // 3: nine calls saturate the stack, eight returns unwind, ninth is unpredicted
    for (int k = 0; k < 9; k++) begin
      clearIn();
      valid_i = 2'b01; is_call_i[0] = 1'b1; pc_i[31:0] = 32'h1000 + 32'(k * 16);
      tick();
    end
    clearIn();
    #2;
    chkState("sat", 3'd1, 4'd8);
    for (int r = 0; r < 8; r++) begin
      clearIn();
      valid_i = 2'b01; is_jalr_i[0] = 1'b1; is_ret_i[0] = 1'b1; pc_i[31:0] = 32'h2000;
      #2;
      chk($sformatf("ret%0d_flush", r), 64'(flush_o), 64'd1);
      chk($sformatf("ret%0d_target", r), 64'(redirect_pc_o), 64'h1084 - 64'(r * 16));
      tick();
    end
    clearIn();
    valid_i = 2'b01; is_jalr_i[0] = 1'b1; is_ret_i[0] = 1'b1; pc_i[31:0] = 32'h2000;
    #2;
    chkState("ret8_pre", 3'd1, 4'd0);
    chk("ret8_flush", 64'(flush_o), 64'd0);
    chk("ret8_pa", 64'(pred_addr_o[31:0]), 64'd0);
    tick();
    clearIn();
    #2;
    chkState("ret8_post", 3'd1, 4'd0);

    // 4: non-control lane predicted taken
    valid_i = 2'b11; pred_taken_i[0] = 1'b1; pc_i[31:0] = 32'h500;
    is_call_i[1] = 1'b1; pc_i[63:32] = 32'h600;
    #2;
    chk("nc_flush", 64'(flush_o), 64'd1);
    chk("nc_lane", 64'(flush_lane_o), 64'd0);
    chk("nc_redirect", 64'(redirect_pc_o), 64'h504);
    chk("nc_valid", 64'(valid_o), 64'b01);
    chk("nc_pa0", 64'(pred_addr_o[31:0]), 64'h504);
    tick();
    clearIn();
    #2;
    chkState("nc_after", 3'd1, 4'd0);

    // 5: recovery overrides a same-cycle call
    valid_i = 2'b11; is_call_i[1] = 1'b1; pc_i[63:32] = 32'h700;
    recover_i = 1'b1; recover_ptr_i = 3'd3; recover_cnt_i = 4'd2;
    #2;
    chk("rec_flush", 64'(flush_o), 64'd0);
    chk("rec_valid", 64'(valid_o), 64'd0);
    tick();
    recover_i = 1'b0;
    clearIn();
    #2;
    chkState("rec_after", 3'd3, 4'd2);

    // 6: return held under stall, popped once on release
    stall = 1'b1;
    valid_i = 2'b01; is_jalr_i[0] = 1'b1; is_ret_i[0] = 1'b1; pc_i[31:0] = 32'h800;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) stall = 1'b0;
      #2;
      chk($sformatf("stl%0d_flush", s), 64'(flush_o), 64'd1);
      chk($sformatf("stl%0d_target", s), 64'(redirect_pc_o), 64'h1024);
      chkState($sformatf("stl%0d", s), 3'd3, 4'd2);
      tick();
    end
    clearIn();
    #2;
    chkState("stl_after", 3'd2, 4'd1);

    // Lane 1 return mispredicted against a lane 0 push in the same group
    valid_i = 2'b11;
    is_call_i[0] = 1'b1; pc_i[31:0] = 32'h900;
    is_jalr_i[1] = 1'b1; is_ret_i[1] = 1'b1; pc_i[63:32] = 32'h980;
    #2;
    chk("l1_flush", 64'(flush_o), 64'd1);
    chk("l1_lane", 64'(flush_lane_o), 64'd1);
    chk("l1_redirect", 64'(redirect_pc_o), 64'h904);
    chk("l1_valid", 64'(valid_o), 64'b11);
    tick();
    clearIn();
    #2;
    chkState("l1_after", 3'd2, 4'd1);

    // Serialising instruction always redirects to the next sequential PC
    valid_i = 2'b11; is_serial_i[0] = 1'b1; pc_i[31:0] = 32'hA00;
    #2;
    chk("ser_flush", 64'(flush_o), 64'd1);
    chk("ser_redirect", 64'(redirect_pc_o), 64'hA04);
    chk("ser_valid", 64'(valid_o), 64'b01);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
